// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// frame limits and the checksum target value.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int         MAX_LEN   = 16;
  localparam logic [7:0] CSUM_GOOD = 8'h00;

  // States in which a frame is in flight and the byte stream is consumed.
  function automatic logic is_busy(input state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader: LEN, N data bytes, CSUM. It writes the data bytes
// into program RAM words 0..N-1 and holds the CPU off the bus while loading.
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = MAX_LEN,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_ram_we,
  output logic [DATA_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_error
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   len_q, cnt_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]  sum_next;
  logic                   accept;
  logic                   len_bad;
  logic                   last_data;
  logic                   load_len;
  logic                   wr_en;

  assign accept    = i_rx_valid && o_rx_ready;
  assign sum_next  = acc_q + i_rx_data;
  assign len_bad   = (i_rx_data == '0) || (i_rx_data > DATA_WIDTH'(MEM_SIZE));
  assign last_data = (cnt_q == len_q - CNT_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    load_len = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: if (i_start) state_d = LEN;
      LEN: if (accept) begin
        load_len = !len_bad;
        state_d  = len_bad ? ERROR : DATA;
      end
      DATA: if (accept) begin
        wr_en = 1'b1;
        if (last_data) state_d = CSUM;
      end
      CSUM: if (accept) state_d = (sum_next == DATA_WIDTH'(CSUM_GOOD)) ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each flag changes on the same
  // edge as the state it describes; hold also covers the cycle of the final write.
  // NOTE: sequential state uses non-blocking assignments only; the RAM itself lives
  // outside this block, so an async reset here never disturbs words already written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      o_rx_ready <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_data <= '0;
      o_cpu_hold <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_rx_ready <= is_busy(state_d);
      o_cpu_hold <= is_busy(state_d) || wr_en;
      o_done     <= (state_d == DONE);
      o_error    <= (state_d == ERROR);
      o_ram_we   <= wr_en;
      if (load_len) begin
        len_q <= i_rx_data[CNT_WIDTH-1:0];
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (wr_en) begin
        o_ram_addr <= DATA_WIDTH'(cnt_q);
        o_ram_data <= i_rx_data;
        cnt_q      <= cnt_q + CNT_WIDTH'(1);
        acc_q      <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: good/bad frames, illegal
// lengths, a full 16-word load with stalls, reset mid-load and a stray start.
module tb_program_loader;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_rx_ready;
  logic       o_ram_we;
  logic [7:0] o_ram_addr;
  logic [7:0] o_ram_data;
  logic       o_cpu_hold;
  logic       o_done;
  logic       o_error;

  program_loader dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_rx_ready (o_rx_ready),
    .o_ram_we   (o_ram_we),
    .o_ram_addr (o_ram_addr),
    .o_ram_data (o_ram_data),
    .o_cpu_hold (o_cpu_hold),
    .o_done     (o_done),
    .o_error    (o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Write log captured from the RAM port, sampled mid-cycle.
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  bit         wr_hold_q[$];
  logic [7:0] shadow[16];

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (o_ram_we === 1'b1) begin
      wr_addr_q.push_back(o_ram_addr);
      wr_data_q.push_back(o_ram_data);
      wr_cyc_q.push_back(cyc);
      wr_hold_q.push_back(o_cpu_hold);
      if (o_ram_addr < 8'd16) shadow[o_ram_addr[3:0]] = o_ram_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    wr_hold_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Present a byte and return at the negedge after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (o_rx_ready !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("rx_ready_wait", 32'(n < 20), 32'd1);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
    check({tag, "_we"},    32'(o_ram_we),   32'd0);
    check({tag, "_addr"},  32'(o_ram_addr), 32'd0);
    check({tag, "_data"},  32'(o_ram_data), 32'd0);
    check({tag, "_hold"},  32'(o_cpu_hold), 32'd0);
    check({tag, "_done"},  32'(o_done),     32'd0);
    check({tag, "_error"}, 32'(o_error),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [7:0] exp_a3[3];
    logic [7:0] fill[16];

    i_rst_n = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
    foreach (shadow[i]) shadow[i] = 8'hxx;
    idle(2);
    check_outputs_zero("reset");
    i_rst_n = 1'b1;
    idle(2);
    check("idle_ready", 32'(o_rx_ready), 32'd0);

    // Good 3-byte load; checksum is the two's complement of the data sum (0x16).
    clear_log();
    pulse_start();
    check("start_hold",  32'(o_cpu_hold), 32'd1);
    check("start_ready", 32'(o_rx_ready), 32'd1);
    send_byte(8'h03);
    check("len_no_write", 32'(wr_addr_q.size()), 32'd0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hEA);
    check("good3_done",  32'(o_done),     32'd1);
    check("good3_error", 32'(o_error),    32'd0);
    check("good3_hold",  32'(o_cpu_hold), 32'd0);
    check("good3_ready", 32'(o_rx_ready), 32'd0);
    idle(1);
    check("good3_nwr", 32'(wr_addr_q.size()), 32'd3);
    exp_a3 = '{8'hA1, 8'hB2, 8'hC3};
    if (wr_addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("good3_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
        check($sformatf("good3_data%0d", i), 32'(wr_data_q[i]), 32'(exp_a3[i]));
      end
      check("good3_b2b", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'd2);
      check("good3_hold_last_wr", 32'(wr_hold_q[2]), 32'd1);
    end

    // Checksum error; a later start clears the sticky error.
    clear_log();
    pulse_start();
    check("restart_done_clr", 32'(o_done), 32'd0);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h00);
    check("bad_csum_error", 32'(o_error),    32'd1);
    check("bad_csum_done",  32'(o_done),     32'd0);
    check("bad_csum_hold",  32'(o_cpu_hold), 32'd0);
    idle(1);
    check("bad_csum_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("bad_csum_w0", 32'(shadow[0]), 32'h10);
    check("bad_csum_w1", 32'(shadow[1]), 32'h20);
    pulse_start();
    check("restart_error_clr", 32'(o_error), 32'd0);

    // Illegal lengths 0 and 17 go straight to ERROR without writes.
    clear_log();
    send_byte(8'h00);
    check("len0_error", 32'(o_error),    32'd1);
    check("len0_ready", 32'(o_rx_ready), 32'd0);
    check("len0_hold",  32'(o_cpu_hold), 32'd0);
    pulse_start();
    send_byte(8'h11);
    check("len17_error", 32'(o_error),    32'd1);
    check("len17_done",  32'(o_done),     32'd0);
    check("len17_ready", 32'(o_rx_ready), 32'd0);
    idle(2);
    check("badlen_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Full 16-word load with random stalls; sum of 0..15 is 0x78, checksum 0x88.
    clear_log();
    pulse_start();
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 3));
      send_byte(8'(i));
    end
    idle($urandom_range(1, 3));
    send_byte(8'h88);
    check("full_done",  32'(o_done),  32'd1);
    check("full_error", 32'(o_error), 32'd0);
    idle(1);
    check("full_nwr", 32'(wr_addr_q.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 8'(i)) bad++;
    check("full_order", 32'(bad), 32'd0);
    fill = shadow;
    check("full_w15", 32'(fill[15]), 32'h0F);

    // Reset during a 4-byte frame after the second data byte.
    clear_log();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h5A);
    send_byte(8'h6B);
    #2 i_rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_rx_valid = 1'b1; i_rx_data = 8'h77;
    idle(3);
    i_rx_valid = 1'b0;
    check("midrst_idle_ready", 32'(o_rx_ready), 32'd0);
    check("midrst_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("midrst_w0", 32'(shadow[0]), 32'h5A);
    check("midrst_w1", 32'(shadow[1]), 32'h6B);
    check("midrst_w2", 32'(shadow[2]), 32'h02);
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h89);
    check("fresh_done", 32'(o_done), 32'd1);
    idle(1);
    check("fresh_nwr", 32'(wr_addr_q.size()), 32'd2);
    check("fresh_w0", 32'(shadow[0]), 32'h33);
    check("fresh_w1", 32'(shadow[1]), 32'h44);

    // A start pulse during DATA is ignored.
    clear_log();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h01);
    i_start = 1'b1;
    send_byte(8'h02);
    i_start = 1'b0;
    check("stray_start_hold", 32'(o_cpu_hold), 32'd1);
    send_byte(8'h03);
    send_byte(8'hFA);
    check("stray_start_done",  32'(o_done),  32'd1);
    check("stray_start_error", 32'(o_error), 32'd0);
    idle(1);
    check("stray_start_nwr", 32'(wr_addr_q.size()), 32'd3);
    check("stray_start_w2", 32'(shadow[2]), 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
